// File: rtl/branch_redirect_unit_if.sv
// Signal bundle between branch execute, fetch, the predictor and the branch redirect unit.
// The unit itself connects through the slave modport.
interface branch_redirect_unit_if #(
  parameter int NUM_BRANCH = 1,
  parameter int ROB_IDX_W  = 7
);
  logic [NUM_BRANCH-1:0]           branch_result_valid;
  logic [NUM_BRANCH-1:0]           branch_actual_taken;
  logic [NUM_BRANCH-1:0]           branch_mispredicted;
  logic [32*NUM_BRANCH-1:0]        branch_correct_pc;
  logic [32*NUM_BRANCH-1:0]        branch_result_pc;
  logic [ROB_IDX_W*NUM_BRANCH-1:0] branch_result_rob_idx;
  logic [ROB_IDX_W-1:0]            rob_head_idx;
  logic                            flush;
  logic [ROB_IDX_W-1:0]            recover_rob_idx;
  logic                            recover_busy;
  logic                            redirect_valid;
  logic [31:0]                     redirect_pc;
  logic                            redirect_ready;
  logic                            bpu_upd_valid;
  logic                            bpu_upd_ready;
  logic [31:0]                     bpu_upd_pc;
  logic [31:0]                     bpu_upd_target;
  logic                            bpu_upd_taken;
  logic                            bpu_upd_mispredict;
  logic [15:0]                     upd_drop_cnt;

  modport master (
    output branch_result_valid, branch_actual_taken, branch_mispredicted,
           branch_correct_pc, branch_result_pc, branch_result_rob_idx,
           rob_head_idx, redirect_ready, bpu_upd_ready,
    input  flush, recover_rob_idx, recover_busy, redirect_valid, redirect_pc,
           bpu_upd_valid, bpu_upd_pc, bpu_upd_target, bpu_upd_taken,
           bpu_upd_mispredict, upd_drop_cnt
  );

  modport slave (
    input  branch_result_valid, branch_actual_taken, branch_mispredicted,
           branch_correct_pc, branch_result_pc, branch_result_rob_idx,
           rob_head_idx, redirect_ready, bpu_upd_ready,
    output flush, recover_rob_idx, recover_busy, redirect_valid, redirect_pc,
           bpu_upd_valid, bpu_upd_pc, bpu_upd_target, bpu_upd_taken,
           bpu_upd_mispredict, upd_drop_cnt
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Picks the oldest mispredicted branch, drives flush/fetch redirect/rollback sequencing,
// and queues correct-path resolutions for predictor training.
module branch_redirect_unit #(
  parameter int NUM_BRANCH     = 1,
  parameter int ROB_IDX_W      = 7,
  parameter int UPD_FIFO_DEPTH = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  branch_redirect_unit_if.slave br
);
  localparam int PTR_W = (UPD_FIFO_DEPTH > 1) ? $clog2(UPD_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0]       RECOVER_LOAD = 4'(RECOVER_CYCLES);
  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(UPD_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REDIRECT, RECOVER} state_t;

  state_t               state, state_n;
  logic [31:0]          pend_pc, pend_pc_n;
  logic [ROB_IDX_W-1:0] pend_idx, pend_idx_n;
  logic [3:0]           cnt, cnt_n;
  logic                 flush_q;

  logic                 any_misp, latch;
  logic [ROB_IDX_W-1:0] best_idx, best_age, lane_idx, lane_age;
  logic [31:0]          best_pc;
  logic [ROB_IDX_W-1:0] filt_idx;
  logic                 filt_active;
  logic [NUM_BRANCH-1:0] keep;

  logic [31:0]          mem_pc     [UPD_FIFO_DEPTH];
  logic [31:0]          mem_target [UPD_FIFO_DEPTH];
  logic                 mem_taken  [UPD_FIFO_DEPTH];
  logic                 mem_misp   [UPD_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt, free_slots, n_push;
  logic [15:0]          n_drop, drop_cnt;
  logic [NUM_BRANCH-1:0] wr_en;
  logic [PTR_W-1:0]     wr_addr [NUM_BRANCH];
  logic                 pop;

  function automatic logic [ROB_IDX_W-1:0] age_of(input logic [ROB_IDX_W-1:0] idx,
                                                  input logic [ROB_IDX_W-1:0] head);
    return idx - head;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Oldest mispredict among the lanes; a latch happens from IDLE or when it is older than pend_idx
  always_comb begin
    any_misp = 1'b0;
    best_idx = '0;
    best_age = '1;
    best_pc  = '0;
    lane_idx = '0;
    lane_age = '0;
    for (int i = 0; i < NUM_BRANCH; i++) begin
      lane_idx = br.branch_result_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      lane_age = age_of(lane_idx, br.rob_head_idx);
      if (br.branch_result_valid[i] && br.branch_mispredicted[i] &&
          (!any_misp || lane_age < best_age)) begin
        any_misp = 1'b1;
        best_idx = lane_idx;
        best_age = lane_age;
        best_pc  = br.branch_correct_pc[i*32 +: 32];
      end
    end
    latch = any_misp &&
            ((state == IDLE) || (best_age < age_of(pend_idx, br.rob_head_idx)));
  end

  always_comb begin
    state_n    = state;
    pend_pc_n  = pend_pc;
    pend_idx_n = pend_idx;
    cnt_n      = cnt;
    if (latch) begin
      state_n    = REDIRECT;
      pend_pc_n  = best_pc;
      pend_idx_n = best_idx;
      cnt_n      = '0;
    end else begin
      case (state)
        REDIRECT: if (br.redirect_ready) begin
          cnt_n   = RECOVER_LOAD;
          state_n = (RECOVER_LOAD == 4'd0) ? IDLE : RECOVER;
        end
        RECOVER: begin
          cnt_n = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
          if (cnt <= 4'd1) state_n = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend_pc  <= '0;
      pend_idx <= '0;
      cnt      <= '0;
      flush_q  <= 1'b0;
    end else begin
      state    <= state_n;
      pend_pc  <= pend_pc_n;
      pend_idx <= pend_idx_n;
      cnt      <= cnt_n;
      flush_q  <= latch;
    end
  end

  // Lanes younger than the (possibly just latched) mispredict are wrong-path and skipped
  always_comb begin
    filt_active = latch || (state != IDLE);
    filt_idx    = latch ? best_idx : pend_idx;
    keep        = '0;
    for (int i = 0; i < NUM_BRANCH; i++) begin
      keep[i] = br.branch_result_valid[i] &&
                !(filt_active &&
                  (age_of(br.branch_result_rob_idx[i*ROB_IDX_W +: ROB_IDX_W], br.rob_head_idx) >
                   age_of(filt_idx, br.rob_head_idx)));
    end
  end

  // Free slots are taken before this cycle's pop, so a full FIFO drops even when popping
  always_comb begin
    free_slots = DEPTH_C - fifo_cnt;
    n_push     = '0;
    n_drop     = '0;
    wr_en      = '0;
    for (int i = 0; i < NUM_BRANCH; i++) begin
      wr_addr[i] = '0;
      if (keep[i]) begin
        if (n_push < free_slots) begin
          wr_en[i]   = 1'b1;
          wr_addr[i] = wr_ptr + n_push[PTR_W-1:0];
          n_push     = n_push + CNT_W'(1);
        end else begin
          n_drop = n_drop + 16'd1;
        end
      end
    end
    pop = (fifo_cnt != '0) && br.bpu_upd_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      drop_cnt <= '0;
      for (int k = 0; k < UPD_FIFO_DEPTH; k++) begin
        mem_pc[k]     <= '0;
        mem_target[k] <= '0;
        mem_taken[k]  <= 1'b0;
        mem_misp[k]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_BRANCH; i++) begin
        if (wr_en[i]) begin
          mem_pc[wr_addr[i]]     <= br.branch_result_pc[i*32 +: 32];
          mem_target[wr_addr[i]] <= br.branch_correct_pc[i*32 +: 32];
          mem_taken[wr_addr[i]]  <= br.branch_actual_taken[i];
          mem_misp[wr_addr[i]]   <= br.branch_mispredicted[i];
        end
      end
      wr_ptr   <= wr_ptr + n_push[PTR_W-1:0];
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      fifo_cnt <= fifo_cnt + n_push - CNT_W'(pop);
      drop_cnt <= sat_add16(drop_cnt, n_drop);
    end
  end

  assign br.flush              = flush_q;
  assign br.recover_busy       = (state != IDLE);
  assign br.redirect_valid     = (state == REDIRECT);
  assign br.redirect_pc        = pend_pc;
  assign br.recover_rob_idx    = pend_idx;
  assign br.bpu_upd_valid      = (fifo_cnt != '0);
  assign br.bpu_upd_pc         = mem_pc[rd_ptr];
  assign br.bpu_upd_target     = mem_target[rd_ptr];
  assign br.bpu_upd_taken      = mem_taken[rd_ptr];
  assign br.bpu_upd_mispredict = mem_misp[rd_ptr];
  assign br.upd_drop_cnt       = drop_cnt;
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: two lanes, 7-bit ROB index, 4-entry update FIFO, 2 recovery cycles.
module tb_branch_redirect_unit;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  branch_redirect_unit_if #(.NUM_BRANCH(2), .ROB_IDX_W(7)) bi ();

  branch_redirect_unit #(
    .NUM_BRANCH(2), .ROB_IDX_W(7), .UPD_FIFO_DEPTH(4), .RECOVER_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .br   (bi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    bi.branch_result_valid   = '0;
    bi.branch_actual_taken   = '0;
    bi.branch_mispredicted   = '0;
    bi.branch_correct_pc     = '0;
    bi.branch_result_pc      = '0;
    bi.branch_result_rob_idx = '0;
  endtask

  task automatic set_lane(input int lane, input logic taken, input logic misp,
                          input logic [31:0] pc, input logic [31:0] cpc, input logic [6:0] idx);
    bi.branch_result_valid[lane]          = 1'b1;
    bi.branch_actual_taken[lane]          = taken;
    bi.branch_mispredicted[lane]          = misp;
    bi.branch_result_pc[lane*32 +: 32]    = pc;
    bi.branch_correct_pc[lane*32 +: 32]   = cpc;
    bi.branch_result_rob_idx[lane*7 +: 7] = idx;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_lanes();
    bi.rob_head_idx   = '0;
    bi.redirect_ready = 1'b0;
    bi.bpu_upd_ready  = 1'b1;
    #2;
    chk("rst_flush", 32'(bi.flush), 32'd0);
    chk("rst_busy", 32'(bi.recover_busy), 32'd0);
    chk("rst_redir_valid", 32'(bi.redirect_valid), 32'd0);
    chk("rst_upd_valid", 32'(bi.bpu_upd_valid), 32'd0);
    chk("rst_drop", 32'(bi.upd_drop_cnt), 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // Single mispredict
    bi.redirect_ready = 1'b1;
    set_lane(0, 1'b1, 1'b1, 32'h100, 32'h200, 7'd5);
    step();
    chk("t1_flush", 32'(bi.flush), 32'd1);
    chk("t1_redir_valid", 32'(bi.redirect_valid), 32'd1);
    chk("t1_redir_pc", bi.redirect_pc, 32'h200);
    chk("t1_busy", 32'(bi.recover_busy), 32'd1);
    chk("t1_rob_idx", 32'(bi.recover_rob_idx), 32'd5);
    chk("t1_upd_valid", 32'(bi.bpu_upd_valid), 32'd1);
    chk("t1_upd_pc", bi.bpu_upd_pc, 32'h100);
    chk("t1_upd_target", bi.bpu_upd_target, 32'h200);
    chk("t1_upd_misp", 32'(bi.bpu_upd_mispredict), 32'd1);
    chk("t1_upd_taken", 32'(bi.bpu_upd_taken), 32'd1);
    clear_lanes();
    step();
    chk("t1_flush_once", 32'(bi.flush), 32'd0);
    chk("t1_n2_redir_valid", 32'(bi.redirect_valid), 32'd0);
    chk("t1_n2_busy", 32'(bi.recover_busy), 32'd1);
    chk("t1_n2_upd_valid", 32'(bi.bpu_upd_valid), 32'd0);
    step();
    chk("t1_n3_busy", 32'(bi.recover_busy), 32'd1);
    step();
    chk("t1_n4_busy", 32'(bi.recover_busy), 32'd0);

    // Redirect backpressure
    bi.redirect_ready = 1'b0;
    set_lane(0, 1'b0, 1'b1, 32'h120, 32'h300, 7'd20);
    step();
    chk("t2_flush", 32'(bi.flush), 32'd1);
    chk("t2_redir_pc", bi.redirect_pc, 32'h300);
    clear_lanes();
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t2_hold_flush", 32'(bi.flush), 32'd0);
      chk("t2_hold_valid", 32'(bi.redirect_valid), 32'd1);
      chk("t2_hold_pc", bi.redirect_pc, 32'h300);
      chk("t2_hold_idx", 32'(bi.recover_rob_idx), 32'd20);
    end
    bi.redirect_ready = 1'b1;
    step();
    chk("t2_accept_valid", 32'(bi.redirect_valid), 32'd0);
    chk("t2_accept_busy", 32'(bi.recover_busy), 32'd1);
    step();
    step();
    chk("t2_done_busy", 32'(bi.recover_busy), 32'd0);

    // Preemption with head 120
    bi.redirect_ready = 1'b0;
    bi.rob_head_idx   = 7'd120;
    set_lane(0, 1'b1, 1'b1, 32'h140, 32'h400, 7'd3);
    step();
    chk("t3_first_pc", bi.redirect_pc, 32'h400);
    chk("t3_first_flush", 32'(bi.flush), 32'd1);
    chk("t3_first_upd_pc", bi.bpu_upd_pc, 32'h140);
    set_lane(0, 1'b0, 1'b1, 32'h150, 32'h500, 7'd125);
    step();
    chk("t3_preempt_flush", 32'(bi.flush), 32'd1);
    chk("t3_preempt_pc", bi.redirect_pc, 32'h500);
    chk("t3_preempt_idx", 32'(bi.recover_rob_idx), 32'd125);
    chk("t3_preempt_upd_pc", bi.bpu_upd_pc, 32'h150);
    set_lane(0, 1'b1, 1'b1, 32'h160, 32'h600, 7'd10);
    step();
    chk("t3_younger_flush", 32'(bi.flush), 32'd0);
    chk("t3_younger_pc", bi.redirect_pc, 32'h500);
    chk("t3_younger_idx", 32'(bi.recover_rob_idx), 32'd125);
    chk("t3_younger_not_enq", 32'(bi.bpu_upd_valid), 32'd0);
    clear_lanes();
    bi.redirect_ready = 1'b1;
    step();
    chk("t3_accept_valid", 32'(bi.redirect_valid), 32'd0);
    step();
    step();
    chk("t3_done_busy", 32'(bi.recover_busy), 32'd0);

    // Wrong-path filter within one cycle
    bi.rob_head_idx = 7'd0;
    set_lane(0, 1'b0, 1'b0, 32'h170, 32'h174, 7'd9);
    set_lane(1, 1'b1, 1'b1, 32'h180, 32'h800, 7'd4);
    step();
    chk("t4_idx", 32'(bi.recover_rob_idx), 32'd4);
    chk("t4_pc", bi.redirect_pc, 32'h800);
    chk("t4_upd_pc", bi.bpu_upd_pc, 32'h180);
    chk("t4_upd_misp", 32'(bi.bpu_upd_mispredict), 32'd1);
    clear_lanes();
    step();
    chk("t4_only_one", 32'(bi.bpu_upd_valid), 32'd0);
    step();
    step();
    chk("t4_done_busy", 32'(bi.recover_busy), 32'd0);

    // FIFO overflow
    bi.bpu_upd_ready = 1'b0;
    set_lane(0, 1'b1, 1'b0, 32'h1000, 32'h2000, 7'd10);
    set_lane(1, 1'b0, 1'b0, 32'h1004, 32'h2004, 7'd11);
    step();
    set_lane(0, 1'b1, 1'b0, 32'h1008, 32'h2008, 7'd12);
    set_lane(1, 1'b0, 1'b0, 32'h100c, 32'h200c, 7'd13);
    step();
    set_lane(0, 1'b1, 1'b0, 32'h1010, 32'h2010, 7'd14);
    set_lane(1, 1'b0, 1'b0, 32'h1014, 32'h2014, 7'd15);
    step();
    chk("t5_drop2", 32'(bi.upd_drop_cnt), 32'd2);
    chk("t5_head_pc", bi.bpu_upd_pc, 32'h1000);
    chk("t5_head_taken", 32'(bi.bpu_upd_taken), 32'd1);
    clear_lanes();
    bi.bpu_upd_ready = 1'b1;
    set_lane(0, 1'b1, 1'b0, 32'h1018, 32'h2018, 7'd16);
    step();
    chk("t5_drop_on_pop", 32'(bi.upd_drop_cnt), 32'd3);
    chk("t5_pop1_pc", bi.bpu_upd_pc, 32'h1004);
    clear_lanes();
    step();
    chk("t5_pop2_pc", bi.bpu_upd_pc, 32'h1008);
    step();
    chk("t5_pop3_pc", bi.bpu_upd_pc, 32'h100c);
    chk("t5_pop3_target", bi.bpu_upd_target, 32'h200c);
    step();
    chk("t5_empty", 32'(bi.bpu_upd_valid), 32'd0);

    // Asynchronous reset in the middle of recovery
    bi.bpu_upd_ready = 1'b0;
    set_lane(0, 1'b1, 1'b1, 32'h1a0, 32'h900, 7'd7);
    step();
    clear_lanes();
    step();
    chk("t6_pre_busy", 32'(bi.recover_busy), 32'd1);
    chk("t6_pre_upd_valid", 32'(bi.bpu_upd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_flush", 32'(bi.flush), 32'd0);
    chk("t6_rst_busy", 32'(bi.recover_busy), 32'd0);
    chk("t6_rst_redir_valid", 32'(bi.redirect_valid), 32'd0);
    chk("t6_rst_redir_pc", bi.redirect_pc, 32'd0);
    chk("t6_rst_rob_idx", 32'(bi.recover_rob_idx), 32'd0);
    chk("t6_rst_upd_valid", 32'(bi.bpu_upd_valid), 32'd0);
    chk("t6_rst_upd_pc", bi.bpu_upd_pc, 32'd0);
    chk("t6_rst_upd_target", bi.bpu_upd_target, 32'd0);
    chk("t6_rst_upd_taken", 32'(bi.bpu_upd_taken), 32'd0);
    chk("t6_rst_upd_misp", 32'(bi.bpu_upd_mispredict), 32'd0);
    chk("t6_rst_drop", 32'(bi.upd_drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_post_busy", 32'(bi.recover_busy), 32'd0);
    chk("t6_post_upd_valid", 32'(bi.bpu_upd_valid), 32'd0);
    set_lane(0, 1'b0, 1'b1, 32'h1b0, 32'ha00, 7'd2);
    step();
    chk("t6_relatch_flush", 32'(bi.flush), 32'd1);
    chk("t6_relatch_pc", bi.redirect_pc, 32'ha00);
    clear_lanes();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
